// File: rtl/imem_fetch_ctrl_if.sv
// Fetch-controller bus: ROM port, redirect request, and decode-side handshake.
// master = fetch controller, slave = ROM/decode environment.
interface imem_fetch_ctrl_if #(
    parameter int INSTR_WIDTH = 32
);
    logic                   cs_rom;
    logic [INSTR_WIDTH-1:0] pc_addr;
    logic [INSTR_WIDTH-1:0] i_in;
    logic                   redirect_valid;
    logic [INSTR_WIDTH-1:0] redirect_pc;
    logic                   inst_valid;
    logic                   inst_ready;
    logic [INSTR_WIDTH-1:0] inst_data;
    logic [INSTR_WIDTH-1:0] inst_pc;
    logic                   fault;

    modport master (
        output cs_rom, pc_addr, inst_valid, inst_data, inst_pc, fault,
        input  i_in, redirect_valid, redirect_pc, inst_ready
    );

    modport slave (
        input  cs_rom, pc_addr, inst_valid, inst_data, inst_pc, fault,
        output i_in, redirect_valid, redirect_pc, inst_ready
    );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns fetch PC, issues ROM reads into a 2-entry
// prefetch buffer drained by decode; handles redirect/flush and sticky faults.
module imem_fetch_ctrl #(
    parameter int                     INSTR_WIDTH = 32,
    parameter int                     ROM_DEPTH   = 256,
    parameter logic [INSTR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic              clk,
    input  logic              rst,
    imem_fetch_ctrl_if.master bus
);
    localparam logic [INSTR_WIDTH-1:0] LAST_PC = INSTR_WIDTH'(ROM_DEPTH - 4);

    typedef enum logic [1:0] {IDLE, FETCH, FAULT} state_t;

    typedef struct packed {
        logic [INSTR_WIDTH-1:0] word;
        logic [INSTR_WIDTH-1:0] pc;
    } entry_t;

    state_t                 state_q, state_d;
    logic [INSTR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [1:0]             count_q, count_d;
    entry_t                 ent_q [2];
    entry_t                 ent_d [2];

    logic pop, redir, issue, flush, wr_idx;

    assign pop   = (count_q != 2'd0) & bus.inst_ready;
    assign redir = bus.redirect_valid & (state_q != FAULT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            count_q    <= 2'd0;
            ent_q[0]   <= '0;
            ent_q[1]   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            ent_q[0]   <= ent_d[0];
            ent_q[1]   <= ent_d[1];
        end
    end

    // Redirect outranks everything; a misaligned target faults and leaves fetch_pc alone.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        issue      = 1'b0;
        flush      = 1'b0;
        if (redir) begin
            flush = 1'b1;
            if (bus.redirect_pc[1:0] != 2'b00) begin
                state_d = FAULT;
            end else begin
                state_d    = FETCH;
                fetch_pc_d = bus.redirect_pc;
            end
        end else begin
            unique case (state_q)
                IDLE:  state_d = FETCH;
                FETCH: begin
                    if (count_q != 2'd2 || pop) begin
                        // Range check precedes issue so a wrapped PC never reaches the ROM.
                        if (fetch_pc_q > LAST_PC) begin
                            state_d = FAULT;
                        end else begin
                            issue      = 1'b1;
                            fetch_pc_d = fetch_pc_q + INSTR_WIDTH'(4);
                        end
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Head is always slot 0; a pop shifts slot 1 down before the new word lands.
    always_comb begin
        ent_d[0] = ent_q[0];
        ent_d[1] = ent_q[1];
        count_d  = count_q;
        wr_idx   = 1'b0;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            if (pop) begin
                ent_d[0] = ent_q[1];
                count_d  = count_q - 2'd1;
            end
            if (issue) begin
                wr_idx        = count_d[0];
                ent_d[wr_idx] = '{word: bus.i_in, pc: fetch_pc_q};
                count_d       = count_d + 2'd1;
            end
        end
    end

    assign bus.cs_rom     = issue;
    assign bus.pc_addr    = fetch_pc_q;
    assign bus.inst_valid = (count_q != 2'd0);
    assign bus.inst_data  = (count_q != 2'd0) ? ent_q[0].word : '0;
    assign bus.inst_pc    = (count_q != 2'd0) ? ent_q[0].pc   : '0;
    assign bus.fault      = (state_q == FAULT);
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl: expected pops are queued by the stimulus
// and checked by an independent monitor; cycle-level outputs checked inline.
module tb_imem_fetch_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;

    imem_fetch_ctrl_if #(.INSTR_WIDTH(32)) bus ();

    imem_fetch_ctrl #(
        .INSTR_WIDTH(32),
        .ROM_DEPTH  (256),
        .RESET_PC   (32'h0000_0000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        case (a)
            32'h0:   rom_word = 32'h2001_0008;
            32'h4:   rom_word = 32'h3402_000c;
            default: rom_word = {16'hC0DE, a[15:0]};
        endcase
    endfunction

    // Garbage when not selected so a capture in the wrong cycle shows up.
    assign bus.i_in = bus.cs_rom ? rom_word(bus.pc_addr) : 32'hDEAD_BEEF;

    typedef struct {
        logic [31:0] data;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic expect_word(input logic [31:0] data, input logic [31:0] pc);
        exp_t e;
        e.data = data;
        e.pc   = pc;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Reset pulse lands between edges; outputs must clear before any clock.
    task automatic apply_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk1("rst_cs_rom", bus.cs_rom, 1'b0);
        chk1("rst_inst_valid", bus.inst_valid, 1'b0);
        chk("rst_inst_data", bus.inst_data, 32'h0);
        chk("rst_inst_pc", bus.inst_pc, 32'h0);
        chk("rst_pc_addr", bus.pc_addr, 32'h0);
        chk1("rst_fault", bus.fault, 1'b0);
        sb.delete();
        bus.redirect_valid = 1'b0;
        bus.inst_ready     = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    // Monitor: every accepted head must match the oldest expected entry.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.inst_valid && bus.inst_ready) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_pop: got pc %h expected no entry", bus.inst_pc);
                end else begin
                    e = sb.pop_front();
                    chk("pop_data", bus.inst_data, e.data);
                    chk("pop_pc", bus.inst_pc, e.pc);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.inst_ready     = 1'b0;

        // First fetch with decode always ready
        apply_reset();
        bus.inst_ready = 1'b1;
        expect_word(32'h2001_0008, 32'h0);
        expect_word(32'h3402_000c, 32'h4);
        mid(); chk1("idle_cs_rom", bus.cs_rom, 1'b0);
        step();
        mid(); chk1("c1_cs_rom", bus.cs_rom, 1'b1); chk("c1_pc_addr", bus.pc_addr, 32'h0);
        step();
        mid(); chk1("c2_inst_valid", bus.inst_valid, 1'b1);
        step();
        mid();
        step();
        bus.inst_ready = 1'b0;

        // Reset with a word still buffered, then back-pressure
        apply_reset();
        step();
        mid(); chk1("bp_c1_cs", bus.cs_rom, 1'b1); chk("bp_c1_pc", bus.pc_addr, 32'h0);
        step();
        mid(); chk1("bp_c2_cs", bus.cs_rom, 1'b1); chk("bp_c2_pc", bus.pc_addr, 32'h4);
        step();
        for (int i = 0; i < 4; i++) begin
            mid(); chk1("bp_full_cs", bus.cs_rom, 1'b0); chk("bp_full_pc", bus.pc_addr, 32'h8);
            step();
        end
        bus.inst_ready = 1'b1;
        expect_word(32'h2001_0008, 32'h0);
        mid(); chk1("bp_release_cs", bus.cs_rom, 1'b1); chk("bp_release_pc", bus.pc_addr, 32'h8);
        step();

        // Redirect while full
        bus.inst_ready     = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h34;
        mid(); chk1("redir_cycle_cs", bus.cs_rom, 1'b0);
        step();
        bus.redirect_valid = 1'b0;
        bus.inst_ready     = 1'b1;
        mid();
        chk1("redir_n1_valid", bus.inst_valid, 1'b0);
        chk1("redir_n1_cs", bus.cs_rom, 1'b1);
        chk("redir_n1_pc", bus.pc_addr, 32'h34);
        expect_word(32'hC0DE_0034, 32'h34);
        expect_word(32'hC0DE_0038, 32'h38);
        step();
        mid(); chk1("redir_n2_cs", bus.cs_rom, 1'b1); chk("redir_n2_pc", bus.pc_addr, 32'h38);
        step();

        // Misaligned redirect with a same-cycle pop, then a redirect that must be ignored
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h36;
        mid(); chk1("mis_cycle_cs", bus.cs_rom, 1'b0);
        step();
        bus.redirect_pc = 32'h0;
        mid(); chk1("mis_fault", bus.fault, 1'b1); chk1("mis_cs", bus.cs_rom, 1'b0);
        step();
        bus.redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mid();
            chk1("fault_sticky", bus.fault, 1'b1);
            chk1("fault_cs", bus.cs_rom, 1'b0);
            chk("fault_pc_hold", bus.pc_addr, 32'h3C);
            step();
        end

        // Redirect in IDLE to the last legal word, then out-of-range fault
        apply_reset();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFC;
        mid(); chk1("edge_c0_cs", bus.cs_rom, 1'b0);
        step();
        bus.redirect_valid = 1'b0;
        mid(); chk1("edge_c1_cs", bus.cs_rom, 1'b1); chk("edge_c1_pc", bus.pc_addr, 32'hFC);
        step();
        mid(); chk1("edge_c2_cs", bus.cs_rom, 1'b0); chk1("edge_c2_fault", bus.fault, 1'b0);
        step();
        mid(); chk1("edge_c3_fault", bus.fault, 1'b1); chk1("edge_c3_valid", bus.inst_valid, 1'b1);
        step();
        bus.inst_ready = 1'b1;
        expect_word(32'hC0DE_00FC, 32'hFC);
        mid();
        step();
        mid();
        chk1("edge_drained", bus.inst_valid, 1'b0);
        chk1("edge_fault", bus.fault, 1'b1);
        chk1("edge_cs", bus.cs_rom, 1'b0);
        step();

        // Recovery after a mid-cycle reset
        apply_reset();
        step();
        mid(); chk1("rec_c1_cs", bus.cs_rom, 1'b1); chk("rec_c1_pc", bus.pc_addr, 32'h0);
        step();
        chk("sb_empty", 32'(sb.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
